// File: rtl/cas_tape_player.sv
// cas_tape_player
// Captures a .CAS image from the ioctl download stream into an internal byte
// buffer, then replays it as a Colour Genie pulse-encoded tape waveform.
// Each bit cell carries a clock pulse at its start. A 1 bit adds a data pulse
// at mid-cell. Bits are sent MSB first.
//
// Ports:
//   clk_sys        system clock
//   reset_n        asynchronous active-low reset
//   ioctl_*        download stream (download, wr strobe, addr, data, index)
//   tape_play      level: play when 1, pause when 0
//   tape_rewind    single-cycle rewind request
//   tape_out       tape waveform to the glue tape input
//   tape_active    high in FETCH, or in PLAY while tape_play=1
//   tape_done      end of image reached
//   tape_pos       index of the byte currently being played
//   cas_len        bytes loaded (0..2^ADDR_W)
//
// state  | meaning
// IDLE   | stopped, waiting for tape_play
// LOAD   | cassette download in progress, buffer being written
// FETCH1 | buffer address tape_pos presented (synchronous read)
// FETCH2 | read data loaded into shift register, counters reset
// PLAY   | emitting bit cells of the current byte
// DONE   | last byte finished, waiting for rewind or new download
module cas_tape_player #(
    parameter int          ADDR_W       = 16,
    parameter int          BIT_CYCLES   = 14000,
    parameter int          PULSE_CYCLES = 1000,
    parameter logic [7:0]  CAS_INDEX    = 8'd1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    input  logic              tape_play,
    input  logic              tape_rewind,
    output logic              tape_out,
    output logic              tape_active,
    output logic              tape_done,
    output logic [ADDR_W-1:0] tape_pos,
    output logic [ADDR_W:0]   cas_len
);
    localparam int CW = $clog2(BIT_CYCLES);

    // Cell timer counts down from BIT_CYCLES-1, so cell position c maps to
    // cell_cnt = BIT_CYCLES-1-c; pulse windows are expressed in that domain.
    localparam logic [CW-1:0]   CELL_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0]   CLK_LO    = CW'(BIT_CYCLES - PULSE_CYCLES);
    localparam logic [CW-1:0]   DAT_HI    = CW'(BIT_CYCLES - 1 - BIT_CYCLES / 2);
    localparam logic [CW-1:0]   DAT_LO    = CW'(BIT_CYCLES - BIT_CYCLES / 2 - PULSE_CYCLES);
    localparam logic [24:0]     ADDR_CAP  = 25'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] LEN_CAP   = (ADDR_W + 1)'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] LEN_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE, LOAD, FETCH1, FETCH2, PLAY, DONE
    } state_t;

    state_t          state, state_nx;
    logic [7:0]      mem [0:2**ADDR_W-1];
    logic [7:0]      rd_data;
    logic [7:0]      shift;
    logic [2:0]      bit_cnt;
    logic [CW-1:0]   cell_cnt;

    logic            dl_cas;
    logic            in_range;
    logic [ADDR_W:0] wr_len;
    logic [ADDR_W:0] pos_next;
    logic            last_byte;
    logic            byte_end;

    assign dl_cas    = ioctl_download && (ioctl_index == CAS_INDEX);
    assign in_range  = ioctl_addr < ADDR_CAP;
    // Writes past capacity still count toward the length, which saturates.
    assign wr_len    = in_range ? ({1'b0, ioctl_addr[ADDR_W-1:0]} + LEN_ONE) : LEN_CAP;
    assign pos_next  = {1'b0, tape_pos} + LEN_ONE;
    assign last_byte = (pos_next == cas_len);
    assign byte_end  = (state == PLAY) && tape_play && (bit_cnt == 3'd7) && (cell_cnt == '0);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (dl_cas) begin
            state_nx = LOAD;
        end else if (state == LOAD) begin
            state_nx = IDLE;
        end else if (tape_rewind) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (tape_play) state_nx = (cas_len != '0) ? FETCH1 : DONE;
                FETCH1:  state_nx = FETCH2;
                FETCH2:  state_nx = PLAY;
                PLAY:    if (byte_end) state_nx = last_byte ? DONE : FETCH1;
                default: state_nx = state;
            endcase
        end
    end

    always_comb begin
        tape_out    = 1'b0;
        tape_active = 1'b0;
        tape_done   = 1'b0;
        case (state)
            FETCH1, FETCH2: tape_active = 1'b1;
            PLAY: begin
                tape_active = tape_play;
                tape_out    = tape_play &&
                              ((cell_cnt >= CLK_LO) ||
                               (shift[7] && (cell_cnt <= DAT_HI) && (cell_cnt >= DAT_LO)));
            end
            DONE:    tape_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cas_len  <= '0;
            tape_pos <= '0;
            shift    <= '0;
            bit_cnt  <= '0;
            cell_cnt <= '0;
        end else if (dl_cas) begin
            if (state != LOAD) begin
                cas_len  <= '0;
                tape_pos <= '0;
                bit_cnt  <= '0;
                cell_cnt <= '0;
            end else if (ioctl_wr && (wr_len > cas_len)) begin
                cas_len <= wr_len;
            end
        end else if ((state != LOAD) && tape_rewind) begin
            tape_pos <= '0;
        end else if (state == FETCH2) begin
            shift    <= rd_data;
            bit_cnt  <= '0;
            cell_cnt <= CELL_LAST;
        end else if ((state == PLAY) && tape_play) begin
            if (cell_cnt == '0) begin
                cell_cnt <= CELL_LAST;
                bit_cnt  <= bit_cnt + 3'd1;
                shift    <= {shift[6:0], 1'b0};
                if ((bit_cnt == 3'd7) && !last_byte) begin
                    tape_pos <= tape_pos + 1'b1;
                end
            end else begin
                cell_cnt <= cell_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if ((state == LOAD) && dl_cas && ioctl_wr && in_range) begin
            mem[ioctl_addr[ADDR_W-1:0]] <= ioctl_dout;
        end
        rd_data <= mem[tape_pos];
    end

endmodule

// File: tb/tb_cas_tape_player.sv
module tb_cas_tape_player;
    localparam int AW = 4;
    localparam int BC = 16;
    localparam int PC = 2;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [24:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_dout = '0;
    logic [7:0]    ioctl_index = '0;
    logic          tape_play = 1'b0;
    logic          tape_rewind = 1'b0;
    logic          tape_out, tape_active, tape_done;
    logic [AW-1:0] tape_pos;
    logic [AW:0]   cas_len;

    int n_checks = 0;
    int n_fails  = 0;
    logic [7:0] img [0:31];

    always #5 clk_sys = ~clk_sys;

    cas_tape_player #(
        .ADDR_W(AW), .BIT_CYCLES(BC), .PULSE_CYCLES(PC), .CAS_INDEX(8'd1)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .tape_play(tape_play), .tape_rewind(tape_rewind),
        .tape_out(tape_out), .tape_active(tape_active), .tape_done(tape_done),
        .tape_pos(tape_pos), .cas_len(cas_len)
    );

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    // Expected tape level at offset t (0..8*BC-1) into byte b.
    function automatic logic exp_out(input logic [7:0] b, input int t);
        int   bi;
        int   c;
        logic bv;
        bi = t / BC;
        c  = t % BC;
        bv = b[7 - bi];
        return (c < PC) || (bv && (c >= BC / 2) && (c < BC / 2 + PC));
    endfunction

    task automatic download(input logic [7:0] idx, input int n);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick;
        for (int i = 0; i < n; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = img[i];
            tick;
        end
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        tick;
    endtask

    task automatic rewind;
        tape_rewind = 1'b1;
        tick;
        tape_rewind = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick;
        tick;
        n_checks++;
        if ({tape_out, tape_active, tape_done, tape_pos, cas_len} !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: got out=%b act=%b done=%b pos=%0d len=%0d, want all 0",
                     tape_out, tape_active, tape_done, tape_pos, cas_len);
        end
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        img[0] = 8'hA5;
        img[1] = 8'h00;
        download(8'd1, 2);
        n_checks++;
        if (cas_len !== 5'd2) begin
            n_fails++;
            $display("FAIL basic_cas_len: got %0d want 2", cas_len);
        end
        tape_play = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int f = 0; f < 2; f++) begin
                tick;
                n_checks++;
                if ({tape_out, tape_active, tape_pos} !== {1'b0, 1'b1, AW'(b)}) begin
                    n_fails++;
                    $display("FAIL basic_fetch b%0d f%0d: got out=%b act=%b pos=%0d want 0 1 %0d",
                             b, f, tape_out, tape_active, tape_pos, b);
                end
            end
            for (int t = 0; t < 8 * BC; t++) begin
                tick;
                n_checks++;
                if ({tape_out, tape_pos} !== {exp_out(img[b], t), AW'(b)}) begin
                    n_fails++;
                    $display("FAIL basic_wave b%0d t%0d: got out=%b pos=%0d want %b %0d",
                             b, t, tape_out, tape_pos, exp_out(img[b], t), b);
                end
            end
        end
        tick;
        n_checks++;
        if ({tape_done, tape_out, tape_active, tape_pos} !== {1'b1, 1'b0, 1'b0, AW'(1)}) begin
            n_fails++;
            $display("FAIL basic_done: got done=%b out=%b act=%b pos=%0d want 1 0 0 1",
                     tape_done, tape_out, tape_active, tape_pos);
        end
        tape_play = 1'b0;
        tick;
    endtask

    task automatic test_rewind_latency;
        rewind;
        n_checks++;
        if ({tape_done, tape_pos, tape_active, tape_out} !== '0) begin
            n_fails++;
            $display("FAIL rewind_state: got done=%b pos=%0d act=%b out=%b want 0 0 0 0",
                     tape_done, tape_pos, tape_active, tape_out);
        end
        tape_play = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick;
            n_checks++;
            if ({tape_active, tape_out} !== {1'b1, (k == 3)}) begin
                n_fails++;
                $display("FAIL latency_n%0d: got act=%b out=%b want 1 %b",
                         k, tape_active, tape_out, (k == 3));
            end
        end
        for (int t = 1; t < 8 * BC; t++) begin
            tick;
            n_checks++;
            if (tape_out !== exp_out(8'hA5, t)) begin
                n_fails++;
                $display("FAIL replay_wave t%0d: got %b want %b", t, tape_out, exp_out(8'hA5, t));
            end
        end
        tape_play = 1'b0;
        rewind;
    endtask

    task automatic test_pause;
        tape_play = 1'b1;
        tick;
        tick;
        for (int t = 0; t <= 3 * BC + 5; t++) begin
            tick;
            n_checks++;
            if (tape_out !== exp_out(8'hA5, t)) begin
                n_fails++;
                $display("FAIL pause_pre t%0d: got %b want %b", t, tape_out, exp_out(8'hA5, t));
            end
        end
        tape_play = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            n_checks++;
            if ({tape_out, tape_active, tape_pos} !== '0) begin
                n_fails++;
                $display("FAIL pause_hold k%0d: got out=%b act=%b pos=%0d want 0 0 0",
                         k, tape_out, tape_active, tape_pos);
            end
            tick;
        end
        tape_play = 1'b1;
        #1;
        for (int t = 3 * BC + 5; t < 8 * BC; t++) begin
            if (t > 3 * BC + 5) tick;
            n_checks++;
            if ({tape_out, tape_pos} !== {exp_out(8'hA5, t), AW'(0)}) begin
                n_fails++;
                $display("FAIL pause_resume t%0d: got out=%b pos=%0d want %b 0",
                         t, tape_out, tape_pos, exp_out(8'hA5, t));
            end
        end
        tape_play = 1'b0;
        rewind;
    endtask

    task automatic test_index_filter;
        tape_play = 1'b1;
        tick;
        tick;
        for (int b = 0; b < 2; b++) begin
            if (b > 0) begin
                tick;
                tick;
            end
            for (int t = 0; t < 8 * BC; t++) begin
                tick;
                n_checks++;
                if ({tape_out, tape_pos} !== {exp_out(img[b], t), AW'(b)}) begin
                    n_fails++;
                    $display("FAIL filter_wave b%0d t%0d: got out=%b pos=%0d want %b %0d",
                             b, t, tape_out, tape_pos, exp_out(img[b], t), b);
                end
                if ((b == 0) && (t >= 10) && (t < 100)) begin
                    ioctl_index    = 8'd2;
                    ioctl_download = 1'b1;
                    ioctl_wr       = t[0];
                    ioctl_addr     = 25'(t % 2);
                    ioctl_dout     = 8'hFF;
                end else begin
                    ioctl_download = 1'b0;
                    ioctl_wr       = 1'b0;
                end
            end
        end
        tick;
        n_checks++;
        if ({tape_done, tape_pos, cas_len} !== {1'b1, AW'(1), 5'd2}) begin
            n_fails++;
            $display("FAIL filter_done: got done=%b pos=%0d len=%0d want 1 1 2",
                     tape_done, tape_pos, cas_len);
        end
        tape_play = 1'b0;
        rewind;
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 20; i++) img[i] = (i < 16) ? (8'hC0 ^ 8'(i)) : 8'h3F;
        download(8'd1, 20);
        n_checks++;
        if (cas_len !== 5'd16) begin
            n_fails++;
            $display("FAIL overflow_len: got %0d want 16", cas_len);
        end
        tape_play = 1'b1;
        for (int b = 0; b < 16; b++) begin
            tick;
            tick;
            for (int t = 0; t < 8 * BC; t++) begin
                tick;
                n_checks++;
                if ({tape_out, tape_pos} !== {exp_out(img[b], t), AW'(b)}) begin
                    n_fails++;
                    $display("FAIL overflow_wave b%0d t%0d: got out=%b pos=%0d want %b %0d",
                             b, t, tape_out, tape_pos, exp_out(img[b], t), b);
                end
            end
        end
        tick;
        n_checks++;
        if ({tape_done, tape_pos} !== {1'b1, AW'(15)}) begin
            n_fails++;
            $display("FAIL overflow_done: got done=%b pos=%0d want 1 15", tape_done, tape_pos);
        end
        tape_play = 1'b0;
        tick;
    endtask

    task automatic test_empty;
        download(8'd1, 0);
        n_checks++;
        if (cas_len !== 5'd0) begin
            n_fails++;
            $display("FAIL empty_len: got %0d want 0", cas_len);
        end
        tape_play = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick;
            n_checks++;
            if ({tape_done, tape_out, tape_active} !== 3'b100) begin
                n_fails++;
                $display("FAIL empty_done k%0d: got done=%b out=%b act=%b want 1 0 0",
                         k, tape_done, tape_out, tape_active);
            end
        end
        tape_play = 1'b0;
        rewind;
        n_checks++;
        if ({tape_done, tape_pos} !== '0) begin
            n_fails++;
            $display("FAIL empty_rewind: got done=%b pos=%0d want 0 0", tape_done, tape_pos);
        end
    endtask

    task automatic test_mid_play_resets;
        img[0] = 8'hA5;
        img[1] = 8'h00;
        download(8'd1, 2);
        tape_play = 1'b1;
        tick;
        tick;
        for (int t = 0; t < 20; t++) tick;
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        tick;
        n_checks++;
        if ({tape_out, tape_active, tape_done, tape_pos, cas_len} !== '0) begin
            n_fails++;
            $display("FAIL redl_clear: got out=%b act=%b done=%b pos=%0d len=%0d want all 0",
                     tape_out, tape_active, tape_done, tape_pos, cas_len);
        end
        img[0] = 8'h5A;
        img[1] = 8'h81;
        for (int i = 0; i < 2; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = img[i];
            tick;
        end
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        tick;
        n_checks++;
        if (cas_len !== 5'd2) begin
            n_fails++;
            $display("FAIL redl_len: got %0d want 2", cas_len);
        end
        tick;
        tick;
        for (int t = 0; t < 8 * BC; t++) begin
            tick;
            n_checks++;
            if (tape_out !== exp_out(img[0], t)) begin
                n_fails++;
                $display("FAIL redl_wave t%0d: got %b want %b", t, tape_out, exp_out(img[0], t));
            end
        end
        tick;
        tick;
        tick;
        n_checks++;
        if ({tape_out, tape_pos} !== {1'b1, AW'(1)}) begin
            n_fails++;
            $display("FAIL prereset_b1: got out=%b pos=%0d want 1 1", tape_out, tape_pos);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({tape_out, tape_active, tape_done, tape_pos, cas_len} !== '0) begin
            n_fails++;
            $display("FAIL async_reset: got out=%b act=%b done=%b pos=%0d len=%0d want all 0",
                     tape_out, tape_active, tape_done, tape_pos, cas_len);
        end
        #2;
        tape_play = 1'b0;
        reset_n   = 1'b1;
        tick;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_rewind_latency;
        test_pause;
        test_index_filter;
        test_overflow;
        test_empty;
        test_mid_play_resets;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
